// File: rtl/wallace_pkg.sv
// Shared definitions for the Wallace multiplier controllers.
// Contents: controller state encoding, per-step shift amounts,
// operand/product widths and a step-to-shift helper.
package wallace_pkg;

   localparam int OP_W   = 8;
   localparam int PROD_W = 16;

   // Shift applied to the 4x4 partial product at each of the four steps.
   localparam int SH0 = 0;
   localparam int SH1 = 4;
   localparam int SH2 = 4;
   localparam int SH3 = 8;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      MUL  = 2'b01,
      DONE = 2'b10
   } state_e;

   function automatic logic [3:0] step_shift(input logic [1:0] step);
      logic [3:0] sh;
      case (step)
         2'd0:    sh = 4'(SH0);
         2'd1:    sh = 4'(SH1);
         2'd2:    sh = 4'(SH2);
         default: sh = 4'(SH3);
      endcase
      return sh;
   endfunction

endpackage

// File: rtl/wallace_mul8_ctrl_mul4.sv
// Combinational unsigned 4x4 Wallace-tree multiplier.
// Ports:
//   i_x [3:0]  multiplicand
//   i_y [3:0]  multiplier
//   o_p [7:0]  product i_x*i_y
module wallace_mul8_ctrl_mul4 (
   input  logic [3:0] i_x,
   input  logic [3:0] i_y,
   output logic [7:0] o_p
);

   // Counters return {carry, sum}.
   function automatic logic [1:0] fa(input logic x, input logic y, input logic z);
      return {1'b0, x} + {1'b0, y} + {1'b0, z};
   endfunction

   function automatic logic [1:0] ha(input logic x, input logic y);
      return {1'b0, x} + {1'b0, y};
   endfunction

   // w_pp[i][j] = y[i] & x[j], weight i+j.
   logic [3:0] w_pp [4];
   logic [1:0] w_s1_1, w_s1_2, w_s1_3, w_s1_4, w_s1_5;
   logic [1:0] w_s2_3, w_s2_4, w_s2_5, w_s2_6;
   logic [7:0] w_row_s, w_row_c;

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         w_pp[i] = i_x & {4{i_y[i]}};
      end
   end

   // First layer: compress every column of the partial-product array.
   assign w_s1_1 = ha(w_pp[0][1], w_pp[1][0]);
   assign w_s1_2 = fa(w_pp[0][2], w_pp[1][1], w_pp[2][0]);
   assign w_s1_3 = fa(w_pp[0][3], w_pp[1][2], w_pp[2][1]);
   assign w_s1_4 = fa(w_pp[1][3], w_pp[2][2], w_pp[3][1]);
   assign w_s1_5 = ha(w_pp[2][3], w_pp[3][2]);

   // Second layer folds columns 3..6 down to one bit each, leaving only the
   // column-1 carry as a second row for the final adder.
   assign w_s2_3 = fa(w_s1_3[0], w_pp[3][0], w_s1_2[1]);
   assign w_s2_4 = fa(w_s1_4[0], w_s1_3[1], w_s2_3[1]);
   assign w_s2_5 = fa(w_s1_5[0], w_s1_4[1], w_s2_4[1]);
   assign w_s2_6 = fa(w_pp[3][3], w_s1_5[1], w_s2_5[1]);

   assign w_row_s = {w_s2_6[1], w_s2_6[0], w_s2_5[0], w_s2_4[0],
                     w_s2_3[0], w_s1_2[0], w_s1_1[0], w_pp[0][0]};
   assign w_row_c = {5'b0, w_s1_1[1], 2'b0};
   assign o_p     = w_row_s + w_row_c;

endmodule

// File: rtl/wallace_mul8_ctrl.sv
// Sequenced unsigned 8x8 multiplier built from one 4x4 Wallace multiplier
// used over four cycles, accumulating shifted partial products.
// Ports:
//   clk, rst               clock; asynchronous active-high reset
//   in_valid / in_ready    operand handshake (accept when both high)
//   a, b [7:0]             operands, sampled on accept
//   out_valid / out_ready  result handshake; out_valid held until taken
//   product [15:0]         accumulator; holds until the next accept
//   busy                   high whenever not IDLE
//   dbg_state              current FSM state
// Handshake: a transfer happens on a rising edge where valid && ready;
// valid never drops without a transfer, ready may change freely.
module wallace_mul8_ctrl
   import wallace_pkg::*;
#(
   parameter bit EARLY_ZERO = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OP_W-1:0]   a,
   input  logic [OP_W-1:0]   b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PROD_W-1:0] product,
   output logic              busy,
   output state_e            dbg_state
);

   state_e            r_state, w_state_nxt;
   logic [1:0]        r_step;
   logic [OP_W-1:0]   r_a, r_b;
   logic [PROD_W-1:0] r_acc;

   logic              w_accept, w_zero_op;
   logic [3:0]        w_a_nib, w_b_nib;
   logic [7:0]        w_pp;
   logic [PROD_W-1:0] w_pp_sh;

   assign w_accept  = in_valid && (r_state == IDLE);
   assign w_zero_op = (a == '0) || (b == '0);

   // step[0] selects the high nibble of a, step[1] the high nibble of b.
   assign w_a_nib = r_step[0] ? r_a[7:4] : r_a[3:0];
   assign w_b_nib = r_step[1] ? r_b[7:4] : r_b[3:0];

   wallace_mul8_ctrl_mul4 u_mul4 (
      .i_x (w_a_nib),
      .i_y (w_b_nib),
      .o_p (w_pp)
   );

   assign w_pp_sh = {8'b0, w_pp} << step_shift(r_step);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               if (EARLY_ZERO && w_zero_op) w_state_nxt = DONE;
               else                         w_state_nxt = MUL;
            end
         end
         MUL:     if (r_step == 2'd3) w_state_nxt = DONE;
         DONE:    if (out_ready)      w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a    <= '0;
         r_b    <= '0;
         r_acc  <= '0;
         r_step <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_a    <= a;
                  r_b    <= b;
                  r_acc  <= '0;
                  r_step <= '0;
               end
            end
            MUL: begin
               r_acc  <= r_acc + w_pp_sh;
               r_step <= r_step + 2'd1;
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (r_state == IDLE);
   assign busy      = (r_state != IDLE);
   assign out_valid = (r_state == DONE);
   assign product   = r_acc;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_wallace_mul8_ctrl.sv
module tb_wallace_mul8_ctrl;
   import wallace_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        in_valid, nz_in_valid, out_ready;
   logic [7:0]  a, b;
   logic        in_ready, out_valid, busy;
   logic [15:0] product;
   state_e      dbg_state;
   logic        nz_in_ready, nz_out_valid, nz_busy;
   logic [15:0] nz_product;
   state_e      nz_dbg_state;

   wallace_mul8_ctrl #(.EARLY_ZERO(1'b1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .product(product), .busy(busy), .dbg_state(dbg_state)
   );

   wallace_mul8_ctrl #(.EARLY_ZERO(1'b0)) dut_nz (
      .clk(clk), .rst(rst), .in_valid(nz_in_valid), .in_ready(nz_in_ready),
      .a(a), .b(b), .out_valid(nz_out_valid), .out_ready(out_ready),
      .product(nz_product), .busy(nz_busy), .dbg_state(nz_dbg_state)
   );

   // Selected-instance view used by the shared operation task.
   bit          cur_nz = 1'b0;
   logic        c_in_ready, c_out_valid;
   logic [15:0] c_product;
   state_e      c_dbg_state;
   assign c_in_ready  = cur_nz ? nz_in_ready  : in_ready;
   assign c_out_valid = cur_nz ? nz_out_valid : out_valid;
   assign c_product   = cur_nz ? nz_product   : product;
   assign c_dbg_state = cur_nz ? nz_dbg_state : dbg_state;

   // ---------------- scoreboard ----------------
   int          tests = 0;
   int          fails = 0;
   logic [15:0] exp_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one operation from an IDLE cycle, wait (bounded) for the result,
   // optionally stall out_ready for 'stall' DONE cycles, then hand off.
   task automatic do_op(input bit use_nz, input logic [7:0] ia, input logic [7:0] ib,
                        input int exp_lat, input int stall, input string tag);
      int          lat;
      logic [15:0] exp;
      cur_nz = use_nz;
      exp_q.push_back(16'(ia) * 16'(ib));
      a = ia;
      b = ib;
      out_ready = (stall == 0);
      if (use_nz) nz_in_valid = 1'b1;
      else        in_valid    = 1'b1;
      #1;
      chk({tag, " ready_before"}, 32'(c_in_ready), 1);
      tick();
      in_valid    = 1'b0;
      nz_in_valid = 1'b0;
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      lat = 1;
      while (!c_out_valid && lat < 16) begin
         chk({tag, " ready_low_busy"}, 32'(c_in_ready), 0);
         tick();
         lat++;
      end
      chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
      exp = exp_q.pop_front();
      chk({tag, " product"}, 32'(c_product), 32'(exp));
      chk({tag, " ready_low_done"}, 32'(c_in_ready), 0);
      chk({tag, " state_done"}, 32'(c_dbg_state), 32'(DONE));
      for (int s = 0; s < stall; s++) begin
         tick();
         chk({tag, " hold_valid"}, 32'(c_out_valid), 1);
         chk({tag, " hold_product"}, 32'(c_product), 32'(exp));
      end
      out_ready = 1'b1;
      tick();
      chk({tag, " valid_dropped"}, 32'(c_out_valid), 0);
      chk({tag, " ready_after"}, 32'(c_in_ready), 1);
      chk({tag, " product_kept"}, 32'(c_product), 32'(exp));
      out_ready = 1'b0;
   endtask

   logic [7:0] vals [8];

   // ---------------- directed sequence ----------------
   initial begin
      vals = '{8'h00, 8'h01, 8'h0F, 8'h10, 8'h55, 8'hAA, 8'hF0, 8'hFF};
      rst = 1'b1;
      in_valid = 1'b0;
      nz_in_valid = 1'b0;
      out_ready = 1'b0;
      a = 8'h00;
      b = 8'h00;
      #2;
      chk("reset in_ready", 32'(in_ready), 1);
      chk("reset busy", 32'(busy), 0);
      chk("reset out_valid", 32'(out_valid), 0);
      chk("reset product", 32'(product), 0);
      chk("reset state", 32'(dbg_state), 32'(IDLE));
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      tick();

      // Full range
      do_op(1'b0, 8'hFF, 8'hFF, 5, 0, "full_range");

      // Cross terms back-to-back with in_valid held high
      out_ready = 1'b1;
      in_valid = 1'b1;
      a = 8'h12;
      b = 8'h34;
      #1;
      chk("b2b ready_first", 32'(in_ready), 1);
      tick();                       // first accept edge T
      a = 8'hA5;
      b = 8'h0F;
      repeat (4) tick();            // cycle T+5
      chk("b2b first_valid", 32'(out_valid), 1);
      chk("b2b first_product", 32'(product), 32'h03A8);
      chk("b2b ready_in_done", 32'(in_ready), 0);
      tick();                       // cycle T+6: second accept on the next edge
      chk("b2b ready_at_6", 32'(in_ready), 1);
      tick();
      in_valid = 1'b0;
      chk("b2b second_accepted", 32'(busy), 1);
      repeat (3) tick();
      chk("b2b second_not_yet", 32'(out_valid), 0);
      tick();
      chk("b2b second_valid", 32'(out_valid), 1);
      chk("b2b second_product", 32'(product), 32'h09AB);
      tick();
      chk("b2b idle_after", 32'(in_ready), 1);
      out_ready = 1'b0;

      // Zero operand, both settings of EARLY_ZERO
      do_op(1'b0, 8'h00, 8'h5A, 1, 0, "zero_early");
      do_op(1'b1, 8'h00, 8'h5A, 5, 0, "zero_full");
      cur_nz = 1'b0;

      // Backpressure with a concurrent in_valid during DONE
      out_ready = 1'b0;
      in_valid = 1'b1;
      a = 8'h80;
      b = 8'h02;
      tick();
      in_valid = 1'b0;
      repeat (4) tick();
      chk("bp valid", 32'(out_valid), 1);
      chk("bp product", 32'(product), 32'h0100);
      in_valid = 1'b1;
      a = 8'h33;
      b = 8'h44;
      for (int s = 0; s < 3; s++) begin
         tick();
         chk("bp hold_valid", 32'(out_valid), 1);
         chk("bp hold_product", 32'(product), 32'h0100);
         chk("bp not_ready", 32'(in_ready), 0);
      end
      out_ready = 1'b1;
      tick();
      chk("bp handoff", 32'(out_valid), 0);
      chk("bp no_accept_in_done", 32'(product), 32'h0100);
      chk("bp idle", 32'(in_ready), 1);
      in_valid = 1'b0;
      out_ready = 1'b0;
      tick();

      // Reset during step 2
      in_valid = 1'b1;
      a = 8'hC3;
      b = 8'h7E;
      tick();
      in_valid = 1'b0;
      repeat (2) tick();            // cycle T+3, step 2
      chk("rst_mid busy_before", 32'(busy), 1);
      #2 rst = 1'b1;
      #1;
      chk("rst_mid out_valid", 32'(out_valid), 0);
      chk("rst_mid busy", 32'(busy), 0);
      chk("rst_mid in_ready", 32'(in_ready), 1);
      chk("rst_mid product", 32'(product), 0);
      #1 rst = 1'b0;
      tick();
      do_op(1'b0, 8'h07, 8'h09, 5, 0, "after_reset");

      // Operand sweep with random result stalls
      for (int i = 0; i < 8; i++) begin
         for (int j = 0; j < 8; j++) begin
            do_op(1'b0, vals[i], vals[j],
                  (vals[i] == 8'h00 || vals[j] == 8'h00) ? 1 : 5,
                  int'($urandom_range(0, 2)), "sweep");
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
